// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter
//
// Shares one asynchronous off-chip SRAM between the CPU datapath port and a
// debug/loader port. Requests are arbitrated round-robin. Each granted access
// follows the sequence IDLE -> SETUP -> ACCESS -> DONE -> IDLE:
//   SETUP  : chip selected and the address presented, with no strobe active.
//   ACCESS : Mem_OE low (read) or Mem_WE low with the bus driven (write) for
//            RD_WAIT / WR_WAIT cycles. Read data is captured on the last cycle.
//   DONE   : a one-cycle done pulse goes to the granted requester, and write
//            data is held on the bus.
//
// Ports
//   Clk, Reset              clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request (held until cpu_done)
//   cpu_rdata, cpu_done     CPU read data (held until the next CPU read) and
//                           completion pulse
//   dbg_*                   the same set of signals for the debug/loader port
//   sram_addr, sram_dout    SRAM address and write data
//   sram_doe                tristate enable for sram_dout
//   sram_din                data read back from the SRAM bus
//   Mem_CE/UB/LB/OE/WE      SRAM controls, all active-low
// -----------------------------------------------------------------------------
module sram_access_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    G_CPU = 1'b0,
    G_DBG = 1'b1
  } gnt_t;

  state_t            state_q, state_d;
  gnt_t              last_q, last_d;
  gnt_t              gnt_q, gnt_d;
  gnt_t              win;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  // Reset clears the address/data registers too, so the SRAM pins come out
  // of reset at a known all-zero value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      last_q      <= G_DBG;
      gnt_q       <= G_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Next-state logic. The requester inputs are looked at only in IDLE; from
  // SETUP through DONE everything runs from the latched copies.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    win         = G_CPU;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          // On a tie, the requester that was not served last wins.
          if (cpu_req && dbg_req) begin
            win = (last_q == G_CPU) ? G_DBG : G_CPU;
          end else begin
            win = cpu_req ? G_CPU : G_DBG;
          end
          gnt_d   = win;
          last_d  = win;
          we_d    = (win == G_CPU) ? cpu_we    : dbg_we;
          addr_d  = (win == G_CPU) ? cpu_addr  : dbg_addr;
          wdata_d = (win == G_CPU) ? cpu_wdata : dbg_wdata;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // The counter is reloaded for every access, so a previous abort never
        // leaves a stale count behind.
        cnt_d   = we_q ? WR_LOAD : RD_LOAD;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (gnt_q == G_CPU) cpu_rdata_d = sram_din;
            else                dbg_rdata_d = sram_din;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin decode from registered state only. Mem_OE is low only for a read, and
  // Mem_WE and sram_doe are active only for a write, so the read strobe never
  // overlaps the write strobe or a driven bus.
  always_comb begin
    Mem_CE   = 1'b1;
    Mem_UB   = 1'b1;
    Mem_LB   = 1'b1;
    Mem_OE   = 1'b1;
    Mem_WE   = 1'b1;
    sram_doe = 1'b0;
    cpu_done = 1'b0;
    dbg_done = 1'b0;

    case (state_q)
      S_SETUP: begin
        Mem_CE = 1'b0;
        Mem_UB = 1'b0;
        Mem_LB = 1'b0;
      end
      S_ACCESS: begin
        Mem_CE = 1'b0;
        Mem_UB = 1'b0;
        Mem_LB = 1'b0;
        if (we_q) begin
          Mem_WE   = 1'b0;
          sram_doe = 1'b1;
        end else begin
          Mem_OE = 1'b0;
        end
      end
      S_DONE: begin
        Mem_CE   = 1'b0;
        Mem_UB   = 1'b0;
        Mem_LB   = 1'b0;
        sram_doe = we_q;   // data hold after Mem_WE rises
        cpu_done = (gnt_q == G_CPU);
        dbg_done = (gnt_q == G_DBG);
      end
      default: begin
      end
    endcase
  end

  assign sram_addr = addr_q;
  assign sram_dout = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule
